// File: rtl/acc_out_port.sv
// acc_out_port: store-side FIFO that drains CPU store data to a peripheral over valid/ready
module acc_out_port #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              CLR,
   input  logic [DATA_W-1:0] acc_in,
   input  logic [DATA_W-1:0] reg_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic              S1,
   input  logic              S0,
   input  logic              StoreOut,
   input  logic              ClrOvf,
   output logic [DATA_W-1:0] port_data,
   output logic              port_valid,
   input  logic              port_ready,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count,
   output logic              ovf
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [DATA_W-1:0] din;
   logic              push, pop, drop;

   // source mux plus handshake decode; outputs depend only on registered state
   always_comb begin
      din        = S1 ? imm_in : (S0 ? reg_in : acc_in);
      full       = count == CNT_W'(DEPTH);
      empty      = count == '0;
      port_valid = ~empty;
      port_data  = mem[rd_ptr];
      pop        = port_valid & port_ready;
      push       = StoreOut & (~full | pop);
      drop       = StoreOut & full & ~pop;
   end

   // storage: write the muxed word at the write pointer on an accepted push
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // pointers wrap naturally since DEPTH is a power of two; count tracks occupancy separately
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= (push & ~pop) ? count + 1'b1 : (pop & ~push) ? count - 1'b1 : count;
      end
   end

   // sticky overflow flag; a dropped store wins over a simultaneous clear
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) ovf <= 1'b0;
      else     ovf <= drop | (ovf & ~ClrOvf);
   end
endmodule

// File: tb/tb_acc_out_port.sv
// tb_acc_out_port: directed scoreboard bench for acc_out_port
module tb_acc_out_port;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       CLR = 1'b1;
   logic [7:0] acc_in = '0, reg_in = '0, imm_in = '0;
   logic       S1 = 1'b0, S0 = 1'b0, StoreOut = 1'b0, ClrOvf = 1'b0, port_ready = 1'b0;
   logic [7:0] port_data;
   logic       port_valid, full, empty, ovf;
   logic [2:0] count;

   int         n_assert = 0;
   int         n_fail = 0;
   logic [7:0] q[$];
   logic [7:0] exp_w = '0;
   logic       m_ovf = 1'b0;

   acc_out_port #(.DATA_W(8), .DEPTH(D), .CNT_W(3)) dut (
      .clk(clk), .CLR(CLR), .acc_in(acc_in), .reg_in(reg_in), .imm_in(imm_in),
      .S1(S1), .S0(S0), .StoreOut(StoreOut), .ClrOvf(ClrOvf),
      .port_data(port_data), .port_valid(port_valid), .port_ready(port_ready),
      .full(full), .empty(empty), .count(count), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // selected source carries w, the others carry distinct decoys
   task automatic set_src(input logic [1:0] sel, input logic [7:0] w);
      {S1, S0} = sel;
      acc_in = ~w;
      reg_in = w ^ 8'h5A;
      imm_in = w + 8'h33;
      if (sel == 2'b00) acc_in = w;
      else if (sel == 2'b01) reg_in = w;
      else imm_in = w;
      exp_w = w;
   endtask

   // one clock with the current inputs: check head before the edge, update model, check status after
   task automatic cyc();
      logic pop, push;
      chk("valid", port_valid, q.size() > 0);
      if (q.size() > 0) chk("data", port_data, q[0]);
      pop  = port_ready && q.size() > 0;
      push = StoreOut && (q.size() < D || pop);
      if (pop) void'(q.pop_front());
      if (push) q.push_back(exp_w);
      m_ovf = (StoreOut && !push) || (m_ovf && !ClrOvf);
      @(posedge clk);
      #1;
      chk("count", count, q.size());
      chk("full", full, q.size() == D);
      chk("empty", empty, q.size() == 0);
      chk("ovf", ovf, m_ovf);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_data"}, port_data, 8'h00);
      chk({tag, "_valid"}, port_valid, 1'b0);
      chk({tag, "_empty"}, empty, 1'b1);
      chk({tag, "_full"}, full, 1'b0);
      chk({tag, "_count"}, count, 3'd0);
      chk({tag, "_ovf"}, ovf, 1'b0);
   endtask

   // pulse CLR between edges and check outputs clear without any clock edge
   task automatic async_reset(input string tag);
      #3 CLR = 1'b1;
      #1 chk_reset(tag);
      q.delete();
      m_ovf = 1'b0;
      #2 CLR = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [1:0] sel, input logic [7:0] w, input logic rdy);
      set_src(sel, w);
      StoreOut = 1'b1;
      port_ready = rdy;
      cyc();
      StoreOut = 1'b0;
   endtask

   task automatic idle(input logic rdy, input int n);
      StoreOut = 1'b0;
      port_ready = rdy;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      #1 chk_reset("rst0");
      @(posedge clk);
      #1 CLR = 1'b0;

      for (int i = 0; i < 5; i++) store(2'b00, 8'h70 + 8'(i), 1'b0);
      async_reset("rst_mid");

      store(2'b00, 8'h5A, 1'b0);
      idle(1'b0, 3);
      idle(1'b1, 1);
      idle(1'b0, 1);

      store(2'b00, 8'h11, 1'b0);
      store(2'b01, 8'h22, 1'b0);
      store(2'b10, 8'h33, 1'b0);
      store(2'b11, 8'h44, 1'b0);
      idle(1'b1, 4);
      idle(1'b0, 1);

      for (int i = 1; i <= 5; i++) store(2'b01, 8'(i), 1'b0);
      idle(1'b1, 4);
      idle(1'b0, 2);
      ClrOvf = 1'b1;
      cyc();
      ClrOvf = 1'b0;
      cyc();

      for (int i = 0; i < 4; i++) store(2'b10, 8'hF0 + 8'(i), 1'b0);
      ClrOvf = 1'b1;
      store(2'b10, 8'hFF, 1'b0);
      cyc();
      ClrOvf = 1'b0;
      idle(1'b1, 4);

      for (int i = 0; i < 4; i++) store(2'b00, 8'hA0 + 8'(i), 1'b0);
      for (int i = 0; i < 4; i++) store(2'b01, 8'hB0 + 8'(i), 1'b1);
      idle(1'b1, 4);
      idle(1'b0, 1);

      for (int i = 0; i < 10; i++) begin
         store(2'b11, 8'hC0 + 8'(i), 1'b0);
         idle(1'b1, 1);
      end

      for (int i = 0; i < 3; i++) store(2'b00, 8'hD0 + 8'(i), 1'b0);
      async_reset("rst_async");
      store(2'b00, 8'hEE, 1'b0);
      idle(1'b1, 1);
      idle(1'b0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
